// File: rtl/integral_image_gen_pkg.sv
// Shared defaults, address-width helper and FSM encoding for the integral image generator.
package integral_image_gen_pkg;

  localparam int DEF_IMG_W = 160;
  localparam int DEF_IMG_H = 120;
  localparam int DEF_PIX_W = 4;
  localparam int DEF_SUM_W = 20;
  localparam int DEF_SQ_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Ceiling log2 with a floor of one bit so single-entry ranges still get a port.
  function automatic int addrWidth(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/integral_image_gen_line_buffer.sv
// One-row line buffer: synchronous write, asynchronous read, so reading the column being
// written in the same cycle still yields the previous row's value.
module ii_line_buffer
  import integral_image_gen_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = DEF_SUM_W
)(
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [addrWidth(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]              wdata_i,
  input  logic [addrWidth(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]              rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/integral_image_gen.sv
// Streaming integral-image generator: one write per accepted pixel, one cycle later,
// with an optional squared-integral channel sharing the same line buffer.
module integral_image_gen
  import integral_image_gen_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W,
  parameter int SUM_W = DEF_SUM_W,
  parameter int SQ_EN = 0,
  parameter int SQ_W  = DEF_SQ_W
)(
  input  logic                                 pclk,
  input  logic                                 rst,
  input  logic                                 frame_start,
  input  logic                                 pix_valid,
  input  logic [PIX_W-1:0]                     pix_data,
  output logic                                 ii_we,
  output logic [addrWidth(IMG_W*IMG_H)-1:0]    ii_addr,
  output logic [SUM_W-1:0]                     ii_data,
  output logic [SQ_W-1:0]                      sq_data,
  output logic                                 frame_done,
  output logic                                 overrun
);

  localparam int ADDR_W = addrWidth(IMG_W*IMG_H);
  localparam int COL_W  = addrWidth(IMG_W);
  localparam int ROW_W  = addrWidth(IMG_H);
  localparam int LB_W   = (SQ_EN != 0) ? SUM_W + SQ_W : SUM_W;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  state_t              state_q;
  logic                armed_q;
  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [SUM_W-1:0]    rowSum_q;
  logic [SQ_W-1:0]     sqRowSum_q;
  logic                ii_we_q;
  logic [ADDR_W-1:0]   ii_addr_q;
  logic [SUM_W-1:0]    ii_data_q;
  logic [SQ_W-1:0]     sq_data_q;
  logic                frame_done_q;
  logic                overrun_q;

  logic                accept;
  logic                lastCol;
  logic                lastPix;
  logic [2*PIX_W-1:0]  pixSq;
  logic [SUM_W-1:0]    rowSum_d;
  logic [SQ_W-1:0]     sqRowSum_d;
  logic [SUM_W-1:0]    iiAbove;
  logic [SQ_W-1:0]     sqAbove;
  logic [SUM_W-1:0]    iiSum_d;
  logic [SQ_W-1:0]     sqSum_d;
  logic [LB_W-1:0]     lbWdata;
  logic [LB_W-1:0]     lbRdata;

  // After reset, armed_q stays low until frame_start is seen so a frame never starts mid-stream.
  assign accept  = pix_valid && !frame_start &&
                   ((state_q == ST_ACTIVE) || ((state_q == ST_IDLE) && armed_q));
  assign lastCol = (col_q == LAST_COL);
  assign lastPix = lastCol && (row_q == LAST_ROW);

  assign pixSq      = (2*PIX_W)'(pix_data) * (2*PIX_W)'(pix_data);
  assign rowSum_d   = rowSum_q + SUM_W'(pix_data);
  assign sqRowSum_d = sqRowSum_q + SQ_W'(pixSq);
  assign iiAbove    = (row_q == '0) ? '0 : lbRdata[SUM_W-1:0];
  assign iiSum_d    = rowSum_d + iiAbove;
  assign sqSum_d    = sqRowSum_d + sqAbove;

  generate
    if (SQ_EN != 0) begin : g_sq
      assign lbWdata = {sqSum_d, iiSum_d};
      assign sqAbove = (row_q == '0) ? '0 : lbRdata[LB_W-1:SUM_W];
    end else begin : g_nosq
      assign lbWdata = iiSum_d;
      assign sqAbove = '0;
    end
  endgenerate

  ii_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (LB_W)
  ) u_line_buffer (
    .clk_i   (pclk),
    .we_i    (accept),
    .waddr_i (col_q),
    .wdata_i (lbWdata),
    .raddr_i (col_q),
    .rdata_o (lbRdata)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      rowSum_q     <= '0;
      sqRowSum_q   <= '0;
      ii_we_q      <= 1'b0;
      ii_addr_q    <= '0;
      ii_data_q    <= '0;
      sq_data_q    <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      ii_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (frame_start) begin
        state_q    <= ST_IDLE;
        armed_q    <= 1'b1;
        col_q      <= '0;
        row_q      <= '0;
        addr_q     <= '0;
        rowSum_q   <= '0;
        sqRowSum_q <= '0;
        overrun_q  <= 1'b0;
      end else begin
        if ((state_q == ST_IDLE) && armed_q) state_q <= ST_ACTIVE;
        if ((state_q == ST_DONE) && pix_valid) overrun_q <= 1'b1;
        if (accept) begin
          ii_we_q   <= 1'b1;
          ii_addr_q <= addr_q;
          ii_data_q <= iiSum_d;
          sq_data_q <= (SQ_EN != 0) ? sqSum_d : '0;
          addr_q    <= addr_q + 1'b1;
          if (lastCol) begin
            col_q      <= '0;
            row_q      <= row_q + 1'b1;
            rowSum_q   <= '0;
            sqRowSum_q <= '0;
          end else begin
            col_q      <= col_q + 1'b1;
            rowSum_q   <= rowSum_d;
            sqRowSum_q <= sqRowSum_d;
          end
          if (lastPix) begin
            state_q      <= ST_DONE;
            frame_done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign ii_we      = ii_we_q;
  assign ii_addr    = ii_addr_q;
  assign ii_data    = ii_data_q;
  assign sq_data    = sq_data_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_integral_image_gen.sv
// Scoreboard bench: a small 4x3 instance with the squared channel and narrow sums (wrap-around),
// plus a default-sized instance streaming a constant frame.
module tb_integral_image_gen;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int PW   = 4;
  localparam int SW   = 7;
  localparam int QW   = 10;
  localparam int NPIX = W * H;
  localparam int BW   = 160;
  localparam int BH   = 120;
  localparam int BN   = BW * BH;

  typedef struct {
    int addr;
    int ii;
    int sq;
    bit done;
  } expEntry_t;

  logic pclk = 1'b0;
  logic rst, frameStart, pixValid;
  logic [PW-1:0] pixData;
  logic iiWe, frameDone, overrun;
  logic [3:0] iiAddr;
  logic [SW-1:0] iiData;
  logic [QW-1:0] sqData;

  logic bigRst, bigFs, bigValid;
  logic [3:0] bigData;
  logic bigWe, bigDone, bigOverrun;
  logic [14:0] bigAddr;
  logic [19:0] bigIi;
  logic [23:0] bigSq;

  int checks = 0;
  int errors = 0;
  expEntry_t expQ[$];
  expEntry_t monEntry;
  int framePix[NPIX];
  int pixCount = 0;
  bit frameActive = 1'b0;
  logic [63:0] lastAddr, lastIi, lastSq;
  logic lastDone;
  int bigCount = 0;
  int bigX, bigY;
  logic [63:0] bigLastIi = '0;

  always #5 pclk = ~pclk;

  integral_image_gen #(
    .IMG_W (W), .IMG_H (H), .PIX_W (PW), .SUM_W (SW), .SQ_EN (1), .SQ_W (QW)
  ) dut (
    .pclk (pclk), .rst (rst), .frame_start (frameStart), .pix_valid (pixValid),
    .pix_data (pixData), .ii_we (iiWe), .ii_addr (iiAddr), .ii_data (iiData),
    .sq_data (sqData), .frame_done (frameDone), .overrun (overrun)
  );

  integral_image_gen dutBig (
    .pclk (pclk), .rst (bigRst), .frame_start (bigFs), .pix_valid (bigValid),
    .pix_data (bigData), .ii_we (bigWe), .ii_addr (bigAddr), .ii_data (bigIi),
    .sq_data (bigSq), .frame_done (bigDone), .overrun (bigOverrun)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge pclk);
    #1;
  endtask

  // Reference: integral value is the plain 2-D sum of every pixel above-left, inclusive.
  function automatic expEntry_t modelEntry(input int n);
    expEntry_t e;
    longint s, q;
    int x, y;
    x = n % W;
    y = n / W;
    s = 0;
    q = 0;
    for (int j = 0; j <= y; j++)
      for (int i = 0; i <= x; i++) begin
        s += framePix[j*W+i];
        q += framePix[j*W+i] * framePix[j*W+i];
      end
    e.addr = n;
    e.ii   = int'(s % (longint'(1) << SW));
    e.sq   = int'(q % (longint'(1) << QW));
    e.done = (n == NPIX - 1);
    return e;
  endfunction

  task automatic applyStimulus(input bit valid, input int data);
    pixValid   = valid;
    pixData    = PW'(data);
    frameStart = 1'b0;
    if (valid && frameActive && pixCount < NPIX) begin
      framePix[pixCount] = data;
      expQ.push_back(modelEntry(pixCount));
      pixCount++;
    end
    cycle();
  endtask

  // frame_start high for two cycles with a pixel offered that must be dropped.
  task automatic startFrame();
    frameStart = 1'b1;
    pixValid   = 1'b1;
    pixData    = PW'($urandom_range(1, 15));
    cycle();
    cycle();
    checkOutput("overrun_cleared", 64'(overrun), 64'(0));
    frameStart  = 1'b0;
    pixValid    = 1'b0;
    pixCount    = 0;
    frameActive = 1'b1;
    cycle();
  endtask

  task automatic sendPixels(input int target, input int constVal);
    int guard;
    guard = 0;
    while (pixCount < target && guard < 400) begin
      if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 0);
      else applyStimulus(1'b1, (constVal < 0) ? int'($urandom_range(0, 15)) : constVal);
      guard++;
    end
    pixValid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 8 && expQ.size() != 0; k++) cycle();
    checkOutput(name, 64'(expQ.size()), 64'(0));
  endtask

  always @(negedge pclk) begin
    if (!rst) begin
      if (iiWe) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr %0d, expected no write", iiAddr);
        end else begin
          monEntry = expQ.pop_front();
          checkOutput("addr", 64'(iiAddr), 64'(monEntry.addr));
          checkOutput("ii_data", 64'(iiData), 64'(monEntry.ii));
          checkOutput("sq_data", 64'(sqData), 64'(monEntry.sq));
          checkOutput("frame_done", 64'(frameDone), 64'(monEntry.done));
        end
        lastAddr = 64'(iiAddr);
        lastIi   = 64'(iiData);
        lastSq   = 64'(sqData);
        lastDone = frameDone;
      end else begin
        checkOutput("done_without_we", 64'(frameDone), 64'(0));
      end
    end
  end

  always @(negedge pclk) begin
    if (!bigRst && bigWe) begin
      bigX = bigCount % BW;
      bigY = bigCount / BW;
      checkOutput("big_addr", 64'(bigAddr), 64'(bigCount));
      checkOutput("big_ii", 64'(bigIi), 64'((bigX + 1) * (bigY + 1) * 15));
      checkOutput("big_done", 64'(bigDone), 64'(bigCount == BN - 1));
      checkOutput("big_sq", 64'(bigSq), 64'(0));
      bigLastIi = 64'(bigIi);
      bigCount++;
    end
  end

  task automatic smallSeq();
    #2;
    checkOutput("rst_we", 64'(iiWe), 64'(0));
    checkOutput("rst_addr", 64'(iiAddr), 64'(0));
    checkOutput("rst_ii", 64'(iiData), 64'(0));
    checkOutput("rst_sq", 64'(sqData), 64'(0));
    checkOutput("rst_done", 64'(frameDone), 64'(0));
    checkOutput("rst_overrun", 64'(overrun), 64'(0));
    cycle();
    rst = 1'b0;
    cycle();

    startFrame();
    sendPixels(NPIX, 1);
    drain("drain_ones");
    checkOutput("ones_last_addr", lastAddr, 64'(11));
    checkOutput("ones_last_ii", lastIi, 64'(12));
    checkOutput("ones_last_done", 64'(lastDone), 64'(1));

    startFrame();
    sendPixels(NPIX, 3);
    drain("drain_threes");
    checkOutput("threes_last_ii", lastIi, 64'(36));
    checkOutput("threes_last_sq", lastSq, 64'(108));

    for (int f = 0; f < 4; f++) begin
      startFrame();
      sendPixels(NPIX, -1);
      drain("drain_random");
    end

    checkOutput("overrun_before", 64'(overrun), 64'(0));
    applyStimulus(1'b1, 5);
    applyStimulus(1'b1, 7);
    pixValid = 1'b0;
    cycle();
    checkOutput("overrun_set", 64'(overrun), 64'(1));
    repeat (3) cycle();
    checkOutput("overrun_sticky", 64'(overrun), 64'(1));

    startFrame();
    sendPixels(5, -1);
    drain("drain_abort");
    startFrame();
    sendPixels(NPIX, -1);
    drain("drain_after_abort");

    startFrame();
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, int'($urandom_range(1, 15)));
    pixValid = 1'b0;
    cycle();
    cycle();
    checkOutput("pre_reset_queue", 64'(expQ.size()), 64'(0));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_addr", 64'(iiAddr), 64'(0));
    checkOutput("async_rst_ii", 64'(iiData), 64'(0));
    checkOutput("async_rst_sq", 64'(sqData), 64'(0));
    checkOutput("async_rst_we", 64'(iiWe), 64'(0));
    frameActive = 1'b0;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 9);
    pixValid = 1'b0;
    cycle();
    checkOutput("no_write_after_reset", 64'(iiWe), 64'(0));
    checkOutput("addr_after_reset", 64'(iiAddr), 64'(0));
    startFrame();
    sendPixels(NPIX, -1);
    drain("drain_after_reset");
  endtask

  task automatic bigSeq();
    int sent;
    sent = 0;
    repeat (2) cycle();
    bigRst = 1'b0;
    repeat (2) cycle();
    bigFs = 1'b0;
    cycle();
    while (sent < BN) begin
      if ($urandom_range(0, 9) == 0) bigValid = 1'b0;
      else begin
        bigValid = 1'b1;
        bigData  = 4'd15;
        sent++;
      end
      cycle();
    end
    bigValid = 1'b0;
    for (int k = 0; k < 8 && bigCount < BN; k++) cycle();
    checkOutput("big_count", 64'(bigCount), 64'(BN));
    checkOutput("big_last_ii", bigLastIi, 64'(288000));
  endtask

  initial begin
    rst        = 1'b1;
    frameStart = 1'b0;
    pixValid   = 1'b0;
    pixData    = '0;
    bigRst     = 1'b1;
    bigFs      = 1'b1;
    bigValid   = 1'b0;
    bigData    = '0;
    fork
      smallSeq();
      bigSeq();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
